// File: rtl/lookup_table_pkg.sv
// rtl/lookup_table_pkg.sv - shared widths, entry type and default-pattern function for lookup_table
package lookup_table_pkg;

   localparam int LUT_ADDR_W = 4;
   localparam int LUT_DATA_W = 4;
   localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;

   typedef logic [LUT_DATA_W-1:0] lut_entry_t;

   // Gray code of the index at full 32-bit width; callers truncate to their entry width.
   function automatic logic [31:0] lut_default(input int unsigned idx);
      int unsigned gray;
      gray = idx ^ (idx >> 1);
      return 32'(gray);
   endfunction

endpackage

// File: rtl/lookup_table_if.sv
// rtl/lookup_table_if.sv - write/read port bundle of lookup_table
interface lookup_table_if
   import lookup_table_pkg::*;
#(
   parameter int ADDR_W = LUT_ADDR_W,
   parameter int DATA_W = LUT_DATA_W
);

   logic [ADDR_W-1:0] addrW;
   logic [ADDR_W-1:0] addrR;
   logic              WE;
   logic              RE;
   logic [DATA_W-1:0] dataIn;
   logic [DATA_W-1:0] dataOut;

   modport master (
      output addrW,
      output addrR,
      output WE,
      output RE,
      output dataIn,
      input  dataOut
   );

   modport slave (
      input  addrW,
      input  addrR,
      input  WE,
      input  RE,
      input  dataIn,
      output dataOut
   );

endinterface

// File: rtl/lookup_table.sv
// rtl/lookup_table.sv - 16x4 register lookup table, Gray-code default contents, optional LUT_WRITE_BYPASS_EN forwarding
module lookup_table
   import lookup_table_pkg::*;
#(
   parameter int ADDR_W = LUT_ADDR_W,
   parameter int DATA_W = LUT_DATA_W
) (
   input logic           clk,
   input logic           rst,
   lookup_table_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef logic [DATA_W-1:0] entry_t;
   typedef entry_t table_t [DEPTH];

   // Full table image of the Gray-code default pattern.
   function automatic table_t init_table();
      table_t t;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         t[i] = entry_t'(lut_default(i));
      end
      return t;
   endfunction

   // Power-up values match what a reset would load.
   table_t mem_q     = init_table();
   entry_t rd_data_q = '0;
   entry_t rd_data_d;
   logic   fwd_hit;

   // Same-address write during a read; only consulted when forwarding is built in.
   assign fwd_hit = bus.RE && bus.WE && (bus.addrW == bus.addrR);

   // Read register next value: hold when RE is low, otherwise fetch (or forward).
   always_comb begin
      rd_data_d = rd_data_q;
      if (bus.RE) begin
`ifdef LUT_WRITE_BYPASS_EN
         if (fwd_hit) begin
            rd_data_d = bus.dataIn;
         end else begin
            rd_data_d = mem_q[bus.addrR];
         end
`else
         rd_data_d = mem_q[bus.addrR];
`endif
      end
   end

   // Table storage: reset reloads the default pattern, WE writes one entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= init_table();
      end else if (bus.WE) begin
         mem_q[bus.addrW] <= bus.dataIn;
      end
   end

   // Read data register: cleared by reset, otherwise takes the selected value.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

`ifndef LUT_WRITE_BYPASS_EN
   // Read-first build: the hit signal exists only for the forwarding variant.
   logic unused_fwd;
   assign unused_fwd = fwd_hit;
`endif

   assign bus.dataOut = rd_data_q;

endmodule

// File: tb/tb_lookup_table.sv
// tb/tb_lookup_table.sv - directed vector bench for lookup_table
module tb_lookup_table;
   import lookup_table_pkg::*;

   typedef struct {
      string      name;
      logic       rst;
      logic       we;
      logic       re;
      logic [3:0] addr_w;
      logic [3:0] addr_r;
      logic [3:0] din;
      logic [3:0] exp_out;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[$];

   lookup_table_if bus ();

   lookup_table dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef LUT_WRITE_BYPASS_EN
   localparam logic [3:0] SAME_ADDR_EXP = 4'd1;
`else
   localparam logic [3:0] SAME_ADDR_EXP = 4'd14;
`endif

   task automatic add(input string name, input logic r, input logic we, input logic re,
                      input logic [3:0] aw, input logic [3:0] ar, input logic [3:0] din,
                      input logic [3:0] exp_out);
      vec_t v;
      v.name = name; v.rst = r; v.we = we; v.re = re;
      v.addr_w = aw; v.addr_r = ar; v.din = din; v.exp_out = exp_out;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic we, input logic re,
                        input logic [3:0] aw, input logic [3:0] ar, input logic [3:0] din);
      rst        = r;
      bus.WE     = we;
      bus.RE     = re;
      bus.addrW  = aw;
      bus.addrR  = ar;
      bus.dataIn = din;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] exp_out);
      n_checks++;
      if (bus.dataOut === exp_out) begin
         n_pass++;
      end else begin
         $display("FAIL %s: dataOut got %0d expected %0d", name, bus.dataOut, exp_out);
      end
   endtask

   initial begin
      rst        = 1'b0;
      bus.WE     = 1'b0;
      bus.RE     = 1'b0;
      bus.addrW  = '0;
      bus.addrR  = '0;
      bus.dataIn = '0;

      //   name              rst we re  aw  ar  din exp
      add("reset_clear",     1, 0, 0,  0,  0,  0,  0);
      add("read_6",          0, 0, 1,  0,  6,  0,  5);
      add("read_8",          0, 0, 1,  0,  8,  0, 12);
      add("read_11",         0, 0, 1,  0, 11,  0, 14);
      add("read_3",          0, 0, 1,  0,  3,  0,  2);
      add("hold_re0",        0, 0, 0,  0,  0,  0,  2);
      add("write_6_hold",    0, 1, 0,  6,  0,  9,  2);
      add("read_back_6",     0, 0, 1,  0,  6,  0,  9);
      add("reset_again",     1, 0, 0,  0,  0,  0,  0);
      add("read_6_default",  0, 0, 1,  0,  6,  0,  5);
      add("same_addr_wr_rd", 0, 1, 1, 11, 11,  1, SAME_ADDR_EXP);
      add("read_11_new",     0, 0, 1,  0, 11,  0,  1);
      add("rst_over_we_re",  1, 1, 1,  2,  2,  7,  0);
      add("entry_2_kept",    0, 0, 1,  0,  2,  0,  3);
      add("diff_addr_wr_rd", 0, 1, 1,  4,  5, 15,  7);
      add("read_4_new",      0, 0, 1,  0,  4,  0, 15);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr_w, vecs[i].addr_r, vecs[i].din);
         check(vecs[i].name, vecs[i].exp_out);
      end

      // Pipelined sweep after reset: each edge returns the address presented at that edge.
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 1, 0, 4'(i), 0);
         check($sformatf("sweep_%0d", i), lut_entry_t'(lut_default(i)));
      end

      // Back-to-back write then read of a different entry, then the written one.
      drive(0, 1, 0, 9, 0, 6);
      drive(0, 0, 1, 0, 10, 0);
      check("b2b_read_10", 4'd15);
      drive(0, 0, 1, 0, 9, 0);
      check("b2b_read_9", 4'd6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
